// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath widths, fetch FSM states and the
// jump opcodes the control unit decodes into redirects.
package proc_pkg;

   localparam int ADDR_W  = 10;
   localparam int INSTR_W = 18;
   localparam int OPC_W   = 5;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      DRAIN
   } fetch_state_e;

   localparam logic [OPC_W-1:0] OP_JUMP = 5'h10;
   localparam logic [OPC_W-1:0] OP_JE   = 5'h11;
   localparam logic [OPC_W-1:0] OP_JA   = 5'h12;
   localparam logic [OPC_W-1:0] OP_JB   = 5'h13;
   localparam logic [OPC_W-1:0] OP_JAE  = 5'h14;
   localparam logic [OPC_W-1:0] OP_JBE  = 5'h15;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-low reset to RESET_PC, load port
// for redirects (priority) and a modulo-2^ADDR_W increment port.
module pc_reg #(
   parameter int                ADDR_W   = proc_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  pc <= RESET_PC;
      else if (load) pc <= load_addr;
      else if (inc)  pc <= pc + ADDR_W'(1);
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding imem reads, instruction register
// with valid/ready handoff, redirect flush. Optional IFETCH_PERF_CNT_EN adds fetch_count.
module instr_fetch #(
   parameter int                ADDR_W   = proc_pkg::ADDR_W,
   parameter int                INSTR_W  = proc_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_addr
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [15:0]        fetch_count
`endif
);

   import proc_pkg::*;

   fetch_state_e      state, state_nxt;
   logic [ADDR_W-1:0] pc;
   logic              pc_inc;
   logic              capture;
   logic              handshake;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (redirect),
      .load_addr (redirect_addr),
      .inc       (pc_inc),
      .pc        (pc)
   );

   assign handshake = instr_valid & instr_ready;
   assign imem_req  = (state == REQ);
   assign imem_addr = imem_req ? pc : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      pc_inc    = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE:  if (start && !redirect) state_nxt = REQ;
         REQ:   state_nxt = redirect ? DRAIN : WAIT;
         WAIT: begin
            if (imem_valid) begin
               capture   = !redirect;
               pc_inc    = !redirect;
               state_nxt = redirect ? REQ : HOLD;
            end else if (redirect) begin
               state_nxt = DRAIN;
            end
         end
         HOLD:  if (instr_ready || redirect) state_nxt = REQ;
         // The stale response retires the outstanding read even if a redirect lands with it.
         DRAIN: if (imem_valid) state_nxt = REQ;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the instruction register is reset because its value is visible on the ports.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else if (capture) begin
         instr       <= imem_rdata;
         instr_pc    <= pc;
         instr_valid <= 1'b1;
      end else if (handshake || (instr_valid && redirect)) begin
         instr_valid <= 1'b0;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                               fetch_count <= '0;
      else if (handshake && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: reactive memory model plus a scoreboard
// of expected {pc, instr} pairs popped on each completed handshake.
module tb_instr_fetch;

   import proc_pkg::*;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] data;
   } exp_t;

   logic               clk;
   logic               reset_n;
   logic               start;
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_valid;
   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0]  instr_pc;
   logic               instr_valid;
   logic               instr_ready;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_addr;
`ifdef IFETCH_PERF_CNT_EN
   logic [15:0]        fetch_count;
`endif

   instr_fetch dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_valid    (imem_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .redirect      (redirect),
      .redirect_addr (redirect_addr)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .fetch_count   (fetch_count)
`endif
   );

   logic [INSTR_W-1:0] mem [2**ADDR_W];
   exp_t               exp_q[$];
   int                 n_checks = 0;
   int                 n_errors = 0;
   int                 hs_cnt   = 0;
   int                 lat      = 1;
   int                 cnt      = 0;
   int                 overlap  = 0;
   int                 n_req    = 0;
   logic [ADDR_W-1:0]  pend;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_fetch(input logic [ADDR_W-1:0] a);
      exp_q.push_back({a, mem[a]});
   endtask

   task automatic wait_req(input logic [ADDR_W-1:0] a, input string tag);
      int k = 0;
      while (imem_req !== 1'b1 && k < 30) begin
         cyc();
         k++;
      end
      check({tag, "_req"}, 32'(imem_req), 1);
      check({tag, "_addr"}, 32'(imem_addr), 32'(a));
   endtask

   task automatic accept(input string tag);
      int k  = 0;
      int h0 = hs_cnt;
      instr_ready = 1'b1;
      while (hs_cnt == h0 && k < 30) begin
         cyc();
         k++;
      end
      instr_ready = 1'b0;
      check({tag, "_hs"}, 32'(hs_cnt - h0), 1);
   endtask

   // Memory: one response per request after lat cycles; flags a request while one is pending.
   initial begin
      imem_valid = 1'b0;
      imem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         imem_valid = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               imem_valid = 1'b1;
               imem_rdata = mem[pend];
            end
         end
         if (imem_req === 1'b1) begin
            n_req++;
            if (cnt > 0) overlap++;
            pend = imem_addr;
            cnt  = lat;
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               check("sb_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", 32'(instr_pc), 32'(e.pc));
               check("sb_instr", 32'(instr), 32'(e.data));
            end
         end
      end
   end

   initial begin
      int n0;
      int h0;
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] = INSTR_W'(i * 2749 + 341);
      mem[0] = 18'h01234;
      reset_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
      redirect = 1'b0; redirect_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", 32'(imem_req), 0);
      check("rst_addr", 32'(imem_addr), 0);
      check("rst_instr", 32'(instr), 0);
      check("rst_pc", 32'(instr_pc), 0);
      check("rst_valid", 32'(instr_valid), 0);
`ifdef IFETCH_PERF_CNT_EN
      check("rst_cnt", 32'(fetch_count), 0);
`endif
      reset_n = 1'b1;
      cyc();

      // First fetch at latency 1 with ready held high.
      expect_fetch(0);
      start = 1'b1; instr_ready = 1'b1;
      cyc();
      start = 1'b0;
      check("f0_req", 32'(imem_req), 1);
      check("f0_addr", 32'(imem_addr), 0);
      cyc();
      check("f0_wait_nv", 32'(instr_valid), 0);
      cyc();
      check("f0_valid", 32'(instr_valid), 1);
      check("f0_instr", 32'(instr), 32'h01234);
      check("f0_pc", 32'(instr_pc), 0);
      expect_fetch(1);
      cyc();
      check("f1_req", 32'(imem_req), 1);
      check("f1_addr", 32'(imem_addr), 1);
      instr_ready = 1'b0;
      cyc();
      cyc();
      check("f1_valid", 32'(instr_valid), 1);

      // Back-pressure: five stalled cycles in HOLD.
      n0 = n_req;
      repeat (5) begin
         cyc();
         check("stall_valid", 32'(instr_valid), 1);
         check("stall_instr", 32'(instr), 32'(mem[1]));
         check("stall_req", 32'(imem_req), 0);
      end
      check("stall_nreq", 32'(n_req - n0), 0);
      lat = 3;
      accept("f1");
      check("f2_req", 32'(imem_req), 1);
      check("f2_addr", 32'(imem_addr), 2);

      // Redirect in WAIT; the stale response arrives later and must be dropped.
      cyc();
      check("rd_wait_nv", 32'(instr_valid), 0);
      redirect = 1'b1; redirect_addr = 10'h200;
      cyc();
      redirect = 1'b0; lat = 1;
      expect_fetch(10'h200);
      for (int k = 0; k < 30 && imem_req !== 1'b1; k++) begin
         check("drain_nv", 32'(instr_valid), 0);
         cyc();
      end
      wait_req(10'h200, "rd");
      accept("rd");

      // Redirect coincident with the response in WAIT.
      wait_req(10'h201, "co");
      cyc();
      redirect = 1'b1; redirect_addr = 10'h3FF;
      cyc();
      redirect = 1'b0;
      check("co_nv", 32'(instr_valid), 0);
      check("co_req", 32'(imem_req), 1);
      check("co_addr", 32'(imem_addr), 32'h3FF);

      // PC wrap from 10'h3FF to 0.
      expect_fetch(10'h3FF);
      accept("wrap");
      wait_req(10'h000, "wrap");

      // Redirect in HOLD together with ready: the handshake still completes.
      cyc();
      cyc();
      check("hr_valid", 32'(instr_valid), 1);
      h0 = hs_cnt;
      expect_fetch(0);
      instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 10'h050;
      cyc();
      instr_ready = 1'b0; redirect = 1'b0;
      check("hr_hs", 32'(hs_cnt - h0), 1);
      check("hr_nv", 32'(instr_valid), 0);
      check("hr_addr", 32'(imem_addr), 32'h050);
      expect_fetch(10'h050);
      lat = 4;
      accept("hr2");
      wait_req(10'h051, "rs");

      // Reset in WAIT; the late response after release must be ignored.
      cyc();
      reset_n = 1'b0;
      #1;
      check("rs_valid", 32'(instr_valid), 0);
      check("rs_req0", 32'(imem_req), 0);
      check("rs_instr", 32'(instr), 0);
      check("rs_pc", 32'(instr_pc), 0);
      cyc();
      reset_n = 1'b1; lat = 1;
      n0 = n_req;
      repeat (6) begin
         cyc();
         check("rs_nv", 32'(instr_valid), 0);
         check("rs_addr", 32'(imem_addr), 0);
      end
      check("rs_nreq", 32'(n_req - n0), 0);
`ifdef IFETCH_PERF_CNT_EN
      check("rs_cnt", 32'(fetch_count), 0);
`endif

      // Restart from RESET_PC and consume seven instructions.
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         expect_fetch(ADDR_W'(i));
         accept("seq");
      end
`ifdef IFETCH_PERF_CNT_EN
      check("cnt7", 32'(fetch_count), 7);
`endif
      check("sb_left", 32'(exp_q.size()), 0);
      check("overlap", 32'(overlap), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
